// File: rtl/wbs_pkg.sv
// rtl/wbs_pkg.sv - shared types and timing defaults for the write burst scheduler
//
// Purpose: state encoding, default DDR3 write timing and counter sizing helper
// shared by write_burst_scheduler and wbs_beat_mux.
// Ports: none (package).

package wbs_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WAIT    = 3'd2,
    BURST   = 3'd3,
    RECOVER = 3'd4
  } wbs_state_e;

  localparam int CWL_DEF = 5;
  localparam int TWR_DEF = 6;
  localparam int BL_DEF  = 8;

  // Width of a down-counter that must hold the largest of the three loads.
  function automatic int cnt_width(input int cwl, input int twr, input int half_bl);
    int m;
    m = cwl;
    if (twr > m) m = twr;
    if (half_bl > m) m = half_bl;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wbs_beat_mux.sv
// rtl/wbs_beat_mux.sv - registered beat-pair selector for the captured write burst
//
// Purpose: picks beat pair sel out of the registered burst and holds it in an
// output register, so wb_data never has a combinational path from any input.
// Ports:
//   clock, reset      posedge clock, asynchronous active-low reset
//   load              capture the selected beat pair this edge
//   sel [SEL_W]       beat pair index (0 = first)
//   burst [BL*BW]     registered burst, pair k at burst[k*2*BW +: 2*BW]
//   beat [2*BW]       registered beat pair; holds while load is low

module wbs_beat_mux #(
  parameter int BW    = 8,
  parameter int BL    = 8,
  parameter int SEL_W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [SEL_W-1:0]    sel,
  input  logic [BL*BW-1:0]    burst,
  output logic [2*BW-1:0]     beat
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat <= '0;
    end else if (load) begin
      beat <= burst[int'(sel)*2*BW +: 2*BW];
    end
  end

endmodule

// File: rtl/write_burst_scheduler.sv
// rtl/write_burst_scheduler.sv - sequences one DDR3 write burst: command, CWL wait, data, recovery
//
// Purpose: accepts one address + full-burst request, issues a one-cycle WRITE
// command, waits CWL cycles, streams BL/2 beat pairs to the serializer, then
// holds off for TWR cycles before the next request.
// Optional: define WRITE_BURST_SCHED_STATS_EN to add a 32-bit burst_count output.
// Ports:
//   clock, reset            posedge clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_addr, req_data      burst address and full burst data
//   cmd_valid, cmd_addr     one-cycle WRITE command
//   wb_data, wb_valid       beat pairs to the serializer
//   busy                    not IDLE
//   done                    one-cycle pulse after the last data cycle
//   burst_count             completed bursts (stats build only)

module write_burst_scheduler
  import wbs_pkg::*;
#(
  parameter int BW     = 8,
  parameter int BL     = BL_DEF,
  parameter int CWL    = CWL_DEF,
  parameter int TWR    = TWR_DEF,
  parameter int ADDR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [BL*BW-1:0]    req_data,
  output logic                cmd_valid,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [2*BW-1:0]     wb_data,
  output logic                wb_valid,
  output logic                busy,
  output logic                done
`ifdef WRITE_BURST_SCHED_STATS_EN
  ,
  output logic [31:0]         burst_count
`endif
);

  localparam int HALF_BL = BL / 2;
  localparam int CNT_W   = cnt_width(CWL, TWR, HALF_BL);
  localparam int BEAT_W  = (HALF_BL > 1) ? $clog2(HALF_BL) : 1;

  wbs_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [BL*BW-1:0]    burst_q;
  logic                accept;

  assign accept = req_valid && (state_q == IDLE);

  // One counter serves both WAIT (CWL) and RECOVER (TWR); the states never overlap.
  // beat_d defaults to 0 so entering BURST always starts at beat pair 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CMD;
      end
      CMD: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(CWL - 1);
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = BURST;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      BURST: begin
        if (beat_q == BEAT_W'(HALF_BL - 1)) begin
          state_d = RECOVER;
          cnt_d   = CNT_W'(TWR);
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (accept) begin
        addr_q  <= req_addr;
        burst_q <= req_data;
      end
    end
  end

  // The mux loads one edge ahead so the beat register is valid in the same
  // cycle the state register shows BURST.
  wbs_beat_mux #(
    .BW    (BW),
    .BL    (BL),
    .SEL_W (BEAT_W)
  ) u_beat_mux (
    .clock (clock),
    .reset (reset),
    .load  (state_d == BURST),
    .sel   (beat_d),
    .burst (burst_q),
    .beat  (wb_data)
  );

  assign req_ready = (state_q == IDLE);
  assign cmd_valid = (state_q == CMD);
  assign cmd_addr  = cmd_valid ? addr_q : '0;
  assign wb_valid  = (state_q == BURST);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RECOVER) && (cnt_q == CNT_W'(TWR));

`ifdef WRITE_BURST_SCHED_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     burst_count <= '0;
    else if (done)  burst_count <= burst_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_write_burst_scheduler.sv
// tb/tb_write_burst_scheduler.sv - directed scoreboard bench for write_burst_scheduler

module tb_write_burst_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        req_valid, req_ready, cmd_valid, wb_valid, busy, done;
  logic [15:0] req_addr, cmd_addr, wb_data;
  logic [63:0] req_data;

  logic        s_req_valid, s_req_ready, s_cmd_valid, s_wb_valid, s_busy, s_done;
  logic [15:0] s_req_addr, s_cmd_addr, s_wb_data;
  logic [31:0] s_req_data;

`ifdef WRITE_BURST_SCHED_STATS_EN
  logic [31:0] burst_count, s_burst_count;
`endif

  write_burst_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .wb_data   (wb_data),
    .wb_valid  (wb_valid),
    .busy      (busy),
    .done      (done)
`ifdef WRITE_BURST_SCHED_STATS_EN
    ,
    .burst_count (burst_count)
`endif
  );

  write_burst_scheduler #(.BW(8), .BL(4), .CWL(2), .TWR(1), .ADDR_W(16)) dut_s (
    .clock     (clock),
    .reset     (reset),
    .req_valid (s_req_valid),
    .req_ready (s_req_ready),
    .req_addr  (s_req_addr),
    .req_data  (s_req_data),
    .cmd_valid (s_cmd_valid),
    .cmd_addr  (s_cmd_addr),
    .wb_data   (s_wb_data),
    .wb_valid  (s_wb_valid),
    .busy      (s_busy),
    .done      (s_done)
`ifdef WRITE_BURST_SCHED_STATS_EN
    ,
    .burst_count (s_burst_count)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int first_acc;

  logic [15:0] exp_q[$];
  logic [15:0] s_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every qualified beat pair must match the oldest expected one.
  always @(negedge clock) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
      else                   chk("wb_data", {48'd0, wb_data}, {48'd0, exp_q.pop_front()});
    end
    if (s_wb_valid) begin
      if (s_q.size() == 0) chk("s_wb_unexpected", 64'd1, 64'd0);
      else                 chk("s_wb_data", {48'd0, s_wb_data}, {48'd0, s_q.pop_front()});
    end
  end

  // Accept at cycle 0, then check cycles 1..16 against the default timing
  // (CWL=5, BL=8, TWR=6). Inputs switch to a2/d2 right after the accept.
  task automatic do_burst(input logic [15:0] a, input logic [63:0] d, input bit hold,
                          input logic [15:0] a2, input logic [63:0] d2);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int k = 0; k < 4; k++) exp_q.push_back(d[k*16 +: 16]);
    step();
    last_acc  = cyc;
    req_valid = hold;
    req_addr  = a2;
    req_data  = d2;
    chk("cmd_valid_c1", {63'd0, cmd_valid}, 64'd1);
    chk("cmd_addr_c1", {48'd0, cmd_addr}, {48'd0, a});
    chk("req_ready_c1", {63'd0, req_ready}, 64'd0);
    chk("busy_c1", {63'd0, busy}, 64'd1);
    for (int c = 2; c <= 16; c++) begin
      step();
      chk("cmd_valid_off", {63'd0, cmd_valid}, 64'd0);
      chk("wb_valid_window", {63'd0, wb_valid}, {63'd0, (c >= 6 && c <= 9)});
      chk("done_pulse", {63'd0, done}, {63'd0, (c == 10)});
      chk("req_ready_window", {63'd0, req_ready}, {63'd0, (c == 16)});
      if (c == 11) chk("wb_data_hold", {48'd0, wb_data}, {48'd0, d[63:48]});
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    s_req_valid = 1'b0;
    s_req_addr  = '0;
    s_req_data  = '0;
    step();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_wb_data", {48'd0, wb_data}, 64'd0);
    reset = 1'b1;
    step();

    // Reset asserted during beat pair 2 of a burst.
    req_valid = 1'b1;
    req_addr  = 16'h00AA;
    req_data  = 64'h0404_0303_0202_0101;
    for (int k = 0; k < 4; k++) exp_q.push_back(req_data[k*16 +: 16]);
    step();
    req_valid = 1'b0;
    repeat (7) step();
    chk("mid_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("mid_wb_data", {48'd0, wb_data}, 64'h0303);
    reset = 1'b0;
    #1;
    chk("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("arst_wb_data", {48'd0, wb_data}, 64'd0);
    chk("arst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end

    // Single request, inputs cleared after the accept.
    do_burst(16'h0040, 64'h8877_6655_4433_2211, 1'b0, 16'h0000, 64'h0);

    // req_valid held high across two distinct bursts.
    do_burst(16'h0100, 64'h0F0E_0D0C_0B0A_0908, 1'b1, 16'h0200, 64'h1F1E_1D1C_1B1A_1918);
    first_acc = last_acc;
    do_burst(16'h0200, 64'h1F1E_1D1C_1B1A_1918, 1'b0, 16'h0000, 64'h0);
    chk("accept_spacing", 64'(last_acc - first_acc), 64'd16);
`ifdef WRITE_BURST_SCHED_STATS_EN
    chk("burst_count", {32'd0, burst_count}, 64'd3);
`endif

    // Inputs change to unrelated values right after the accept.
    do_burst(16'h1357, 64'hCAFE_F00D_1234_5678, 1'b0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF);

    // Short-timing instance: CWL=2, TWR=1, BL=4.
    s_req_valid = 1'b1;
    s_req_addr  = 16'h0BEE;
    s_req_data  = 32'hD4C3_B2A1;
    s_q.push_back(16'hB2A1);
    s_q.push_back(16'hD4C3);
    step();
    s_req_valid = 1'b0;
    s_req_data  = '0;
    chk("s_cmd_valid_c1", {63'd0, s_cmd_valid}, 64'd1);
    chk("s_cmd_addr_c1", {48'd0, s_cmd_addr}, 64'h0BEE);
    for (int c = 2; c <= 6; c++) begin
      step();
      chk("s_cmd_valid_off", {63'd0, s_cmd_valid}, 64'd0);
      chk("s_wb_valid_window", {63'd0, s_wb_valid}, {63'd0, (c == 3 || c == 4)});
      chk("s_done_pulse", {63'd0, s_done}, {63'd0, (c == 5)});
      chk("s_req_ready_window", {63'd0, s_req_ready}, {63'd0, (c == 6)});
    end

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("s_scoreboard_drained", 64'(s_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
